pac_game_status: RTL and testbench
==================================

# pac_game_status

Gameplay bookkeeping stage directly upstream of the screen-state FSM. It consumes per-cycle gameplay events (pellet eaten, power pellet eaten, ghost contact) and vsync frame ticks. It maintains score, lives, remaining pellets, the frightened-ghost timer and the respawn invulnerability timer, and produces the `pacDeath` and `winsignal` levels that the screen FSM uses to leave the Game state.

## Interface
Parameters:
- `TOTAL_PELLETS`, 244: pellets (including power pellets) in the maze.
- `START_LIVES`, 3: lives at game start (1..3).
- `FRIGHT_FRAMES`, 360: frightened duration, in frames.
- `INVULN_FRAMES`, 120: post-respawn invulnerability, in frames.

Ports:
- `Clk` in 1: system clock. One clock; all logic is on its rising edge.
- `Reset` in 1: reset, synchronous and active-high.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `startscreen` in 1: screen FSM is in Start; level-sensitive game clear.
- `gamescreen` in 1: screen FSM is in Game; enables bookkeeping.
- `pellet_eaten` in 1: one-cycle pulse, normal pellet consumed.
- `power_eaten` in 1: one-cycle pulse, power pellet consumed.
- `ghost_hit` in 1: one-cycle pulse, Pac-Man overlaps a ghost.
- `pacDeath` out 1: level, last life lost.
- `winsignal` out 1: level, all pellets cleared.
- `score` out 16: current score, saturating.
- `lives` out 2: remaining lives.
- `pellets_left` out 8: pellets remaining.
- `frightened` out 1: power mode active.
- `invuln` out 1: respawn invulnerability active.
- `respawn` out 1: one-cycle pulse when a non-final life is lost.

## Operation
- States: IDLE, PLAY, INVULN, DEAD, WON.
- Reset, or `startscreen`=1 in any state, gives this next-edge state:
  - state IDLE; `score`=0, `lives`=START_LIVES, `pellets_left`=TOTAL_PELLETS.
  - All flags 0; both timers 0; ghost chain 0.
- IDLE -> PLAY when `gamescreen`=1.
- PLAY or INVULN with `gamescreen`=0 and `startscreen`=0: all registers frozen, events ignored.
- PLAY and INVULN events:
  - `pellet_eaten`: `score`+=10; `pellets_left`-=1.
  - `power_eaten`: `score`+=50; `pellets_left`-=1; fright timer loads FRIGHT_FRAMES; ghost chain = 0.
  - Both pellet pulses in the same cycle: `score`+=60; `pellets_left`-=2. `pellets_left` saturates at 0.
  - `ghost_hit` while `frightened`: `score` += 200<<chain; chain increments and saturates at 3 (200/400/800/1600).
  - `ghost_hit` while not `frightened`, in PLAY:
    - `lives`=1 -> DEAD, `lives`=0.
    - Otherwise `lives`-=1, `respawn` pulses, invuln timer loads INVULN_FRAMES, go to INVULN.
  - `ghost_hit` while not `frightened`, in INVULN: ignored.
  - `score` saturates at 16'hFFFF.
- `frame_tick` decrements any nonzero timer.
  - Fright timer reaching 0 clears `frightened` and the ghost chain.
  - Invuln timer reaching 0 returns INVULN -> PLAY.
- Next `pellets_left`=0 -> WON. If a fatal hit arrives in the same cycle, win has priority and the hit is ignored.
- Losing a life does not reset power mode.
- DEAD: `pacDeath`=1. WON: `winsignal`=1. Both hold until `startscreen`; all counters frozen.
- `invuln`=1 exactly in INVULN.

## Timing
- All outputs are registered. An event in cycle N is visible in cycle N+1.
- `pacDeath`/`winsignal` assert the cycle after the causing event; the screen FSM transitions one cycle later.
- `respawn` is high for exactly one cycle, aligned with the `lives` decrement.
- Power pellet eaten in the same cycle as `ghost_hit`: the new fright state is not yet active, so the hit is a normal hit.
- Timer load and `frame_tick` in the same cycle: the load wins.
- A timer of FRIGHT_FRAMES expires on the FRIGHT_FRAMES-th `frame_tick` after the load cycle.
- Reset or `startscreen` mid-game overrides every event in that cycle.

## Structure
- Package `pac_game_pkg` holds:
  - The state enum.
  - Point constants: 10, 50, 200.
  - The chain saturation limit.
- One reusable sub-module, `frame_timer`: load/value inputs, `frame_tick` decrement, `active` output. It is instantiated twice (fright, invuln).

## Test plan
- Reset, then `gamescreen`=1, then 244 `pellet_eaten` pulses -> `score`=2440, `pellets_left`=0, `winsignal`=1 one cycle after the last pulse, `pacDeath`=0.
- 3 `ghost_hit` with no power, each after the invuln timer expires -> `respawn` twice, `lives` 2, 1, 0, `pacDeath`=1; later events leave `score` unchanged.
- `power_eaten`, then 5 frightened `ghost_hit` -> `score`=50+200+400+800+1600+1600=4650; after 360 `frame_tick`, `frightened`=0.
- `ghost_hit` two cycles after a respawn -> `lives` unchanged, `invuln`=1; after 120 ticks `invuln`=0 and the next hit decrements `lives`.
- TOTAL_PELLETS=2: `pellet_eaten` and `power_eaten` together, plus a same-cycle fatal `ghost_hit` at `lives`=1 -> `winsignal`=1, `pacDeath`=0.
- `startscreen` pulsed while in DEAD with score 1230 -> next cycle `score`=0, `lives`=3, `pellets_left`=TOTAL_PELLETS, `pacDeath`=0.

Source files
------------

// File: rtl/pac_game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pac_game_pkg
// Purpose  : Shared types and constants for the gameplay bookkeeping stage:
//            the game-status state encoding, point values, ghost-chain limit
//            and a saturating score adder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pac_game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PLAY   = 3'd1,
      ST_INVULN = 3'd2,
      ST_DEAD   = 3'd3,
      ST_WON    = 3'd4
   } state_t;

   localparam logic [15:0] PTS_PELLET = 16'd10;
   localparam logic [15:0] PTS_POWER  = 16'd50;
   localparam logic [15:0] PTS_GHOST  = 16'd200;

   // Ghost chain index saturates here: 200 << 3 = 1600 points per ghost.
   localparam logic [1:0]  CHAIN_MAX  = 2'd3;

   function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                             input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : frame_timer
// Purpose  : Frame-granular down counter. Loads a value, decrements once per
//            frame tick while enabled and flags the tick that reaches zero.
// Ports    : clk        - system clock
//            rst        - synchronous active-high clear
//            en         - counting/loading enable (freezes the count when 0)
//            load       - load request (has priority over tick)
//            load_value - value to load
//            tick       - one-cycle frame pulse
//            active     - count is nonzero
//            expire     - the current tick takes the count from 1 to 0
// Revision : 1.0 - initial release
// ============================================================================
module frame_timer
   import pac_game_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             tick,
   output logic             active,
   output logic             expire
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         if (load)
            count <= load_value;
         else if (tick && (count != '0))
            count <= count - 1'b1;
      end
   end

   assign active = (count != '0);
   assign expire = en && !load && tick && (count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/pac_game_status.sv
`default_nettype none
// ============================================================================
// Module   : pac_game_status
// Purpose  : Gameplay bookkeeping ahead of the screen-state FSM. Tracks score,
//            lives, pellets, frightened mode and respawn invulnerability, and
//            raises pacDeath / winsignal levels to end the Game screen.
// Ports    : Clk, Reset            - clock, synchronous active-high reset
//            frame_tick            - one pulse per video frame
//            startscreen           - level-sensitive game clear
//            gamescreen            - enables bookkeeping
//            pellet_eaten,
//            power_eaten,
//            ghost_hit             - one-cycle gameplay events
//            pacDeath, winsignal   - end-of-game levels
//            score, lives,
//            pellets_left          - counters
//            frightened, invuln    - mode flags
//            respawn               - pulse on non-final life loss
// Revision : 1.0 - initial release
// ============================================================================
module pac_game_status
   import pac_game_pkg::*;
#(
   parameter int TOTAL_PELLETS = 244,
   parameter int START_LIVES   = 3,
   parameter int FRIGHT_FRAMES = 360,
   parameter int INVULN_FRAMES = 120
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic        startscreen,
   input  logic        gamescreen,
   input  logic        pellet_eaten,
   input  logic        power_eaten,
   input  logic        ghost_hit,
   output logic        pacDeath,
   output logic        winsignal,
   output logic [15:0] score,
   output logic [1:0]  lives,
   output logic [7:0]  pellets_left,
   output logic        frightened,
   output logic        invuln,
   output logic        respawn
);

   localparam int FRIGHT_W = $clog2(FRIGHT_FRAMES + 1);
   localparam int INVULN_W = $clog2(INVULN_FRAMES + 1);
   localparam logic [FRIGHT_W-1:0] FRIGHT_LOAD = FRIGHT_W'(FRIGHT_FRAMES);
   localparam logic [INVULN_W-1:0] INVULN_LOAD = INVULN_W'(INVULN_FRAMES);
   localparam logic [7:0]          PEL_INIT    = 8'(TOTAL_PELLETS);
   localparam logic [1:0]          LIVES_INIT  = 2'(START_LIVES);

   state_t      state, state_next;
   logic [15:0] score_next;
   logic [1:0]  lives_next;
   logic [7:0]  pellets_next;
   logic [1:0]  chain, chain_next;
   logic        respawn_next;
   logic        clear;
   logic        run;
   logic        fright_load, invuln_load;
   logic        fright_expire, invuln_expire;
   logic        invuln_active;
   logic        hit_scored, normal_hit, win;
   logic [1:0]  n_pel;
   logic [15:0] points;

   // startscreen is a level-sensitive clear with the same effect as Reset.
   assign clear = Reset || startscreen;

   // Bookkeeping only advances while playing and the Game screen is shown;
   // otherwise everything (timers included) holds.
   assign run = gamescreen && ((state == ST_PLAY) || (state == ST_INVULN));

   assign fright_load = run && power_eaten;

   frame_timer #(.WIDTH(FRIGHT_W)) u_fright_timer (
      .clk        (Clk),
      .rst        (clear),
      .en         (run),
      .load       (fright_load),
      .load_value (FRIGHT_LOAD),
      .tick       (frame_tick),
      .active     (frightened),
      .expire     (fright_expire)
   );

   frame_timer #(.WIDTH(INVULN_W)) u_invuln_timer (
      .clk        (Clk),
      .rst        (clear),
      .en         (run),
      .load       (invuln_load),
      .load_value (INVULN_LOAD),
      .tick       (frame_tick),
      .active     (invuln_active),
      .expire     (invuln_expire)
   );

   always_comb begin
      state_next   = state;
      lives_next   = lives;
      chain_next   = chain;
      respawn_next = 1'b0;
      invuln_load  = 1'b0;
      points       = 16'd0;
      n_pel        = 2'd0;

      // Ghost scoring and normal hits use the registered fright state, so a
      // power pellet in the same cycle as a hit leaves the hit a normal one.
      hit_scored = run && ghost_hit && frightened;
      normal_hit = run && ghost_hit && !frightened && (state == ST_PLAY);

      if (run) begin
         if (pellet_eaten) begin
            points = points + PTS_PELLET;
            n_pel  = n_pel + 2'd1;
         end
         if (power_eaten) begin
            points = points + PTS_POWER;
            n_pel  = n_pel + 2'd1;
         end
         if (hit_scored)
            points = points + (PTS_GHOST << chain);
      end

      score_next   = sat_add16(score, points);
      pellets_next = (pellets_left > {6'd0, n_pel}) ? (pellets_left - {6'd0, n_pel}) : 8'd0;
      win          = run && (pellets_next == 8'd0);

      // Chain restarts with each power pellet and when fright runs out; the
      // score above already used the pre-increment chain value.
      if (fright_load || fright_expire)
         chain_next = 2'd0;
      else if (hit_scored && (chain != CHAIN_MAX))
         chain_next = chain + 2'd1;

      case (state)
         ST_IDLE: begin
            if (gamescreen)
               state_next = ST_PLAY;
         end
         ST_PLAY, ST_INVULN: begin
            // Clearing the maze beats any simultaneous normal hit.
            if (win) begin
               state_next = ST_WON;
            end else if (normal_hit) begin
               if (lives == 2'd1) begin
                  lives_next = 2'd0;
                  state_next = ST_DEAD;
               end else begin
                  lives_next   = lives - 2'd1;
                  respawn_next = 1'b1;
                  invuln_load  = 1'b1;
                  state_next   = ST_INVULN;
               end
            end else if ((state == ST_INVULN) && invuln_expire) begin
               state_next = ST_PLAY;
            end
         end
         default: begin
            state_next = state;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (clear) begin
         state        <= ST_IDLE;
         score        <= 16'd0;
         lives        <= LIVES_INIT;
         pellets_left <= PEL_INIT;
         chain        <= 2'd0;
         respawn      <= 1'b0;
      end else begin
         state        <= state_next;
         score        <= score_next;
         lives        <= lives_next;
         pellets_left <= pellets_next;
         chain        <= chain_next;
         respawn      <= respawn_next;
      end
   end

   assign pacDeath  = (state == ST_DEAD);
   assign winsignal = (state == ST_WON);
   // The invuln timer only runs inside INVULN; the state alone defines the flag.
   assign invuln    = (state == ST_INVULN) || (invuln_active && 1'b0);

endmodule
`default_nettype wire

// File: tb/tb_pac_game_status.sv
`default_nettype none
// ============================================================================
// Module   : tb_pac_game_status
// Purpose  : Self-checking bench for pac_game_status. Stimulus tasks push
//            hand-computed expectations into a queue tagged with the cycle in
//            which they must hold; a monitor on the falling edge pops and
//            compares them against the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pac_game_status;

   logic Clk, Reset, frame_tick, startscreen, gamescreen;
   logic pellet_eaten, power_eaten, ghost_hit;

   logic        pacDeath, winsignal, frightened, invuln, respawn;
   logic [15:0] score;
   logic [1:0]  lives;
   logic [7:0]  pellets_left;

   logic        pacDeath2, winsignal2, frightened2, invuln2, respawn2;
   logic [15:0] score2;
   logic [1:0]  lives2;
   logic [7:0]  pellets_left2;

   pac_game_status u_dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .startscreen(startscreen),
      .gamescreen(gamescreen), .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
      .ghost_hit(ghost_hit), .pacDeath(pacDeath), .winsignal(winsignal), .score(score),
      .lives(lives), .pellets_left(pellets_left), .frightened(frightened),
      .invuln(invuln), .respawn(respawn)
   );

   // Small maze with a single life: exercises win-over-fatal-hit priority.
   pac_game_status #(.TOTAL_PELLETS(2), .START_LIVES(1)) u_dut2 (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .startscreen(startscreen),
      .gamescreen(gamescreen), .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
      .ghost_hit(ghost_hit), .pacDeath(pacDeath2), .winsignal(winsignal2), .score(score2),
      .lives(lives2), .pellets_left(pellets_left2), .frightened(frightened2),
      .invuln(invuln2), .respawn(respawn2)
   );

   localparam int F_SCORE = 0, F_LIVES = 1, F_PEL = 2, F_DEATH = 3, F_WIN = 4;
   localparam int F_FRIGHT = 5, F_INVULN = 6, F_RESPAWN = 7;
   localparam int F2_PEL = 8, F2_DEATH = 9, F2_WIN = 10;

   typedef struct {
      int    cyc;
      int    field;
      int    val;
      string name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc++;

   function automatic int actual(input int f);
      case (f)
         F_SCORE:   return int'(score);
         F_LIVES:   return int'(lives);
         F_PEL:     return int'(pellets_left);
         F_DEATH:   return int'(pacDeath);
         F_WIN:     return int'(winsignal);
         F_FRIGHT:  return int'(frightened);
         F_INVULN:  return int'(invuln);
         F_RESPAWN: return int'(respawn);
         F2_PEL:    return int'(pellets_left2);
         F2_DEATH:  return int'(pacDeath2);
         F2_WIN:    return int'(winsignal2);
         default:   return -1;
      endcase
   endfunction

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge Clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         int   a;
         e = q.pop_front();
         a = actual(e.field);
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
         end else if (a != e.val) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.val, cyc);
         end
      end
   end

   task automatic expect_val(input int f, input int v, input string nm);
      exp_t e;
      e.cyc = cyc; e.field = f; e.val = v; e.name = nm;
      q.push_back(e);
   endtask

   task automatic step(input bit pe, input bit pw, input bit gh, input bit ft);
      pellet_eaten = pe; power_eaten = pw; ghost_hit = gh; frame_tick = ft;
      @(posedge Clk); #1;
      pellet_eaten = 0; power_eaten = 0; ghost_hit = 0; frame_tick = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 1);
   endtask

   task automatic restart();
      startscreen = 1; step(0, 0, 0, 0);
      startscreen = 0; step(0, 0, 0, 0);
   endtask

   initial begin
      int ghost_scores[5] = '{250, 650, 1450, 3050, 4650};
      Reset = 1; startscreen = 0; gamescreen = 0;
      pellet_eaten = 0; power_eaten = 0; ghost_hit = 0; frame_tick = 0;
      @(posedge Clk); #1;
      step(0, 0, 0, 0);
      expect_val(F_SCORE, 0, "rst_score");     expect_val(F_LIVES, 3, "rst_lives");
      expect_val(F_PEL, 244, "rst_pellets");   expect_val(F_DEATH, 0, "rst_death");
      expect_val(F_WIN, 0, "rst_win");         expect_val(F_FRIGHT, 0, "rst_fright");
      expect_val(F_INVULN, 0, "rst_invuln");   expect_val(F_RESPAWN, 0, "rst_respawn");

      // Clear the whole maze.
      Reset = 0; gamescreen = 1;
      step(0, 0, 0, 0);
      for (int k = 1; k <= 244; k++) begin
         step(1, 0, 0, 0);
         if (k == 1) begin
            expect_val(F_SCORE, 10, "pel1_score"); expect_val(F_PEL, 243, "pel1_left");
         end
         if (k == 243) begin
            expect_val(F_PEL, 1, "pel243_left"); expect_val(F_WIN, 0, "pel243_win");
         end
         if (k == 244) begin
            expect_val(F_SCORE, 2440, "clear_score"); expect_val(F_PEL, 0, "clear_left");
            expect_val(F_WIN, 1, "clear_win");        expect_val(F_DEATH, 0, "clear_death");
         end
      end
      step(1, 0, 0, 0);
      expect_val(F_SCORE, 2440, "won_frozen"); expect_val(F_WIN, 1, "won_hold");

      // Start clears both instances; then both pellets plus a same-cycle hit.
      startscreen = 1; step(0, 0, 0, 0);
      expect_val(F_SCORE, 0, "start_score"); expect_val(F_PEL, 244, "start_left");
      expect_val(F_LIVES, 3, "start_lives"); expect_val(F_WIN, 0, "start_win");
      expect_val(F2_PEL, 2, "s2_start_left"); expect_val(F2_WIN, 0, "s2_start_win");
      startscreen = 0; step(0, 0, 0, 0);
      step(1, 1, 1, 0);
      expect_val(F2_WIN, 1, "s2_win");     expect_val(F2_DEATH, 0, "s2_no_death");
      expect_val(F2_PEL, 0, "s2_left");
      expect_val(F_SCORE, 60, "both_score"); expect_val(F_PEL, 242, "both_left");
      expect_val(F_LIVES, 2, "pw_hit_lives"); expect_val(F_RESPAWN, 1, "pw_hit_respawn");
      expect_val(F_INVULN, 1, "pw_hit_invuln"); expect_val(F_FRIGHT, 1, "pw_fright");

      // Frozen while the Game screen is not shown.
      restart();
      gamescreen = 0; step(1, 0, 0, 0);
      expect_val(F_SCORE, 0, "frozen_score"); expect_val(F_PEL, 244, "frozen_left");
      gamescreen = 1;

      // Power pellet (with a same-cycle tick: load wins), then ghost chain.
      step(0, 1, 0, 1);
      expect_val(F_SCORE, 50, "power_score"); expect_val(F_PEL, 243, "power_left");
      expect_val(F_FRIGHT, 1, "power_fright");
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 0);
         expect_val(F_SCORE, ghost_scores[i], "chain_score");
      end
      expect_val(F_LIVES, 3, "chain_lives");
      ticks(359);
      expect_val(F_FRIGHT, 1, "fright_359");
      step(0, 0, 0, 1);
      expect_val(F_FRIGHT, 0, "fright_360");

      // Normal hit, ignored hit during invulnerability, expiry, further hits.
      step(0, 0, 1, 0);
      expect_val(F_LIVES, 2, "hit1_lives"); expect_val(F_RESPAWN, 1, "hit1_respawn");
      expect_val(F_INVULN, 1, "hit1_invuln"); expect_val(F_SCORE, 4650, "hit1_score");
      step(0, 0, 0, 0);
      expect_val(F_RESPAWN, 0, "respawn_pulse");
      step(0, 0, 1, 0);
      expect_val(F_LIVES, 2, "inv_hit_lives"); expect_val(F_INVULN, 1, "inv_hit_invuln");
      ticks(119);
      expect_val(F_INVULN, 1, "invuln_119");
      step(0, 0, 0, 1);
      expect_val(F_INVULN, 0, "invuln_120");
      step(0, 0, 1, 0);
      expect_val(F_LIVES, 1, "hit2_lives"); expect_val(F_RESPAWN, 1, "hit2_respawn");
      ticks(120);
      step(0, 0, 1, 0);
      expect_val(F_LIVES, 0, "hit3_lives"); expect_val(F_DEATH, 1, "hit3_death");
      expect_val(F_RESPAWN, 0, "hit3_no_respawn");
      step(1, 0, 0, 0);
      expect_val(F_SCORE, 4650, "dead_frozen"); expect_val(F_DEATH, 1, "dead_hold");

      // Die with score 1230, then startscreen clears everything.
      restart();
      for (int k = 0; k < 123; k++) step(1, 0, 0, 0);
      step(0, 0, 1, 0); ticks(120);
      step(0, 0, 1, 0); ticks(120);
      step(0, 0, 1, 0);
      expect_val(F_DEATH, 1, "dead2_death"); expect_val(F_SCORE, 1230, "dead2_score");
      expect_val(F_PEL, 121, "dead2_left");
      startscreen = 1; step(0, 0, 0, 0);
      expect_val(F_SCORE, 0, "clr_score"); expect_val(F_LIVES, 3, "clr_lives");
      expect_val(F_PEL, 244, "clr_left");  expect_val(F_DEATH, 0, "clr_death");
      startscreen = 0;

      repeat (3) @(posedge Clk);
      #1;
      if (q.size() != 0) begin
         errors += q.size();
         $display("FAIL drain: %0d expectations never compared", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
